// File: rtl/ate_pkg.sv
// Shared constants for the threshold-engine bin packer.
// Strip length depends on ATE_PACK_THRESH_EN (per-block threshold bytes appended).
package ate_pkg;
  localparam int BLK_DIM         = 8;
  localparam int BLK_PER_STRIP   = 6;
  localparam int BYTES_PER_STRIP = BLK_DIM * BLK_PER_STRIP;
  localparam int THR_BYTES       = BLK_PER_STRIP;
  localparam int ADDR_W          = 6;

  function automatic int strip_len();
`ifdef ATE_PACK_THRESH_EN
    return BYTES_PER_STRIP + THR_BYTES;
`else
    return BYTES_PER_STRIP;
`endif
  endfunction

  localparam int STRIP_LEN = strip_len();

  typedef enum logic {
    WR_STORE = 1'b0,
    WR_DROP  = 1'b1
  } wr_state_e;
endpackage

// File: rtl/ate_bin_packer_if.sv
// Bin input / byte output bundle of the bin packer. Handshake: a byte transfers on
// every rising clk where out_valid && out_ready; bins transfer whenever bin_valid is high.
interface ate_bin_packer_if;
  import ate_pkg::*;

  logic       bin_valid;
  logic       bin;
  logic [7:0] threshold;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       overflow;
  wr_state_e  dbg_wr_state;

  modport master (
    output bin_valid, bin, threshold, out_ready,
    input  out_valid, out_data, out_last, overflow, dbg_wr_state
  );

  modport slave (
    input  bin_valid, bin, threshold, out_ready,
    output out_valid, out_data, out_last, overflow, dbg_wr_state
  );
endinterface

// File: rtl/ate_strip_bank.sv
// Two-bank strip byte memory: one write port, one asynchronous read port,
// and a full flag per bank with independent set/clear.
module ate_strip_bank
  import ate_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic              wbank_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic              rbank_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o,
  input  logic              set_i,
  input  logic              set_bank_i,
  input  logic              clr_i,
  input  logic              clr_bank_i,
  output logic [1:0]        full_o
);
  logic [7:0] mem_q [2][STRIP_LEN];
  logic [1:0] full_q, full_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int a = 0; a < STRIP_LEN; a++) begin
          mem_q[b][a] <= '0;
        end
      end
    end else if (we_i) begin
      mem_q[wbank_i][waddr_i] <= wdata_i;
    end
  end

  // Set and clear normally target different banks; set wins if they ever coincide.
  always_comb begin
    full_d = full_q;
    if (clr_i) full_d[clr_bank_i] = 1'b0;
    if (set_i) full_d[set_bank_i] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) full_q <= '0;
    else       full_q <= full_d;
  end

  assign rdata_o = mem_q[rbank_i][raddr_i];
  assign full_o  = full_q;
endmodule

// File: rtl/ate_bin_packer.sv
// Packs the threshold engine's block-ordered bin stream into raster-ordered strip bytes.
// Build option: ATE_PACK_THRESH_EN appends the six per-block threshold bytes to each strip.
module ate_bin_packer
  import ate_pkg::*;
(
  input logic             clk,
  input logic             reset,
  ate_bin_packer_if.slave bus
);
  localparam logic [2:0]        BLK_LAST = 3'(BLK_PER_STRIP - 1);
  localparam logic [ADDR_W-1:0] RD_LAST  = ADDR_W'(STRIP_LEN - 1);

  logic [5:0]        pix_q, pix_d;
  logic [2:0]        blk_q, blk_d;
  logic              wr_bank_q, wr_bank_d;
  logic [6:0]        sh_q, sh_d;
  wr_state_e         wr_state_q, wr_state_d;
  logic              overflow_q, overflow_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic              first_bin, strip_done, drop_now, dropping;
  logic              out_valid, fire, rd_last, clr_full, set_full;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata, rdata;
  logic [1:0]        full;

  always_comb begin
    pix_d      = pix_q;
    blk_d      = blk_q;
    wr_bank_d  = wr_bank_q;
    sh_d       = sh_q;
    wr_state_d = wr_state_q;
    rd_bank_d  = rd_bank_q;
    rd_ptr_d   = rd_ptr_q;
    we         = 1'b0;
    waddr      = ADDR_W'(pix_q[5:3]) * ADDR_W'(BLK_PER_STRIP) + ADDR_W'(blk_q);
    wdata      = {sh_q, bus.bin};

    out_valid  = full[rd_bank_q];
    fire       = out_valid && bus.out_ready;
    rd_last    = (rd_ptr_q == RD_LAST);
    clr_full   = fire && rd_last;

    first_bin  = bus.bin_valid && (pix_q == 6'd0) && (blk_q == 3'd0);
    strip_done = bus.bin_valid && (pix_q == 6'd63) && (blk_q == BLK_LAST);
    // A bank being drained of its last byte this cycle counts as free.
    drop_now   = full[wr_bank_q] && !(clr_full && (rd_bank_q == wr_bank_q));
    dropping   = (wr_state_q == WR_DROP);
    if (first_bin) begin
      dropping   = drop_now;
      wr_state_d = drop_now ? WR_DROP : WR_STORE;
    end
    overflow_d = overflow_q | (first_bin & drop_now);
    set_full   = strip_done && !dropping;

    if (bus.bin_valid) begin
      sh_d  = {sh_q[5:0], bus.bin};
      pix_d = pix_q + 6'd1;
      if (pix_q == 6'd63) begin
        if (blk_q == BLK_LAST) begin
          blk_d     = 3'd0;
          wr_bank_d = ~wr_bank_q;
        end else begin
          blk_d = blk_q + 3'd1;
        end
      end
      if (!dropping) begin
        if (pix_q[2:0] == 3'd7) begin
          we = 1'b1;
        end
`ifdef ATE_PACK_THRESH_EN
        else if (pix_q == 6'd0) begin
          we    = 1'b1;
          waddr = ADDR_W'(BYTES_PER_STRIP) + ADDR_W'(blk_q);
          wdata = bus.threshold;
        end
`endif
      end
    end

    if (fire) begin
      if (rd_last) begin
        rd_ptr_d  = '0;
        rd_bank_d = ~rd_bank_q;
      end else begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
    end
  end

`ifndef ATE_PACK_THRESH_EN
  logic unused_threshold;
  assign unused_threshold = ^bus.threshold;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q      <= '0;
      blk_q      <= '0;
      wr_bank_q  <= 1'b0;
      sh_q       <= '0;
      wr_state_q <= WR_STORE;
      overflow_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_ptr_q   <= '0;
    end else begin
      pix_q      <= pix_d;
      blk_q      <= blk_d;
      wr_bank_q  <= wr_bank_d;
      sh_q       <= sh_d;
      wr_state_q <= wr_state_d;
      overflow_q <= overflow_d;
      rd_bank_q  <= rd_bank_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  ate_strip_bank u_bank (
    .clk        (clk),
    .reset      (reset),
    .we_i       (we),
    .wbank_i    (wr_bank_q),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .rbank_i    (rd_bank_q),
    .raddr_i    (rd_ptr_q),
    .rdata_o    (rdata),
    .set_i      (set_full),
    .set_bank_i (wr_bank_q),
    .clr_i      (clr_full),
    .clr_bank_i (rd_bank_q),
    .full_o     (full)
  );

  assign bus.out_valid    = out_valid;
  assign bus.out_data     = rdata;
  assign bus.out_last     = out_valid && rd_last;
  assign bus.overflow     = overflow_q;
  assign bus.dbg_wr_state = wr_state_q;
endmodule

// File: tb/tb_ate_bin_packer.sv
// Directed bench for ate_bin_packer: reset, fill/drain patterns, overflow and bank-free race.
module tb_ate_bin_packer;
`ifdef ATE_PACK_THRESH_EN
  localparam int SLEN = 54;
`else
  localparam int SLEN = 48;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ate_bin_packer_if bus ();
  ate_bin_packer dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       got_last_q[$];

  // Bytes are recorded on the negedge preceding the accepting posedge.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_data);
      got_last_q.push_back(bus.out_last);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    bus.bin_valid = 1'b0; bus.bin = 1'b0; bus.threshold = 8'h00; bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete(); got_q.delete(); got_last_q.delete();
  endtask

  function automatic logic pat_bit(input int kind, input int blk, input int pix);
    case (kind)
      1:       return 1'b1;
      2:       return pix[0] ^ pix[3];
      3:       return (blk == 2) && (pix == 9);
      default: return 1'b0;
    endcase
  endfunction

  task automatic send_bin(input logic b, input logic [7:0] thr);
    bus.bin_valid = 1'b1; bus.bin = b; bus.threshold = thr;
    @(posedge clk); #1;
    bus.bin_valid = 1'b0; bus.bin = 1'b0;
  endtask

  task automatic send_range(input int kind, input bit gaps, input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      int blk;
      int pix;
      blk = k / 64;
      pix = k % 64;
      if (gaps && (pix % 5 == 4)) begin
        @(posedge clk); #1;
      end
      send_bin(pat_bit(kind, blk, pix), 8'((blk + 1) * 10));
    end
  endtask

  task automatic push_exp(input int kind);
    for (int i = 0; i < 48; i++) begin
      logic [7:0] v;
      int row;
      row = i / 6;
      case (kind)
        1:       v = 8'hFF;
        2:       v = (row % 2 == 0) ? 8'h55 : 8'hAA;
        3:       v = (i == 8) ? 8'h40 : 8'h00;
        default: v = 8'h00;
      endcase
      exp_q.push_back(v);
    end
    if (SLEN > 48) begin
      for (int b = 0; b < 6; b++) exp_q.push_back(8'((b + 1) * 10));
    end
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    int cyc;
    cyc = 0;
    while (got_q.size() < n && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = (got_q.size() >= n);
    repeat (10) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.bin_valid = 1'b0; bus.bin = 1'b0; bus.threshold = 8'h00; bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
    checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    reset = 1'b0;
    // Full strip held, then a partial one; an asynchronous reset must wipe both.
    send_range(1, 1'b0, 0, 384);
    send_range(2, 1'b0, 0, 100);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hFF) begin
      failures++; $display("FAIL pre_reset_held got valid=%b data=%h exp valid=1 data=ff", bus.out_valid, bus.out_data);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
      failures++; $display("FAIL midstrip_reset got valid=%b data=%h exp valid=0 data=00", bus.out_valid, bus.out_data);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_all_ones();
    bit ok;
    do_reset();
    bus.out_ready = 1'b1;
    send_range(1, 1'b0, 0, 383);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ones_early_valid got=%b exp=0", bus.out_valid); end
    send_bin(1'b1, 8'd60);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ones_valid_latency got=%b exp=1", bus.out_valid); end
    push_exp(1);
    wait_bytes(SLEN, ok);
    checks++; if (got_q.size() != SLEN) begin failures++; $display("FAIL ones_count got=%0d exp=%0d", got_q.size(), SLEN); end
    for (int i = 0; i < SLEN && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == SLEN - 1)) begin
        failures++;
        $display("FAIL ones_byte %0d got data=%h last=%b exp data=%h last=%b", i, got_q[i], got_last_q[i], exp_q[i], (i == SLEN - 1));
      end
    end
  endtask

  task automatic test_checkerboard();
    bit ok;
    do_reset();
    bus.out_ready = 1'b1;
    send_range(2, 1'b1, 0, 384);
    push_exp(2);
    wait_bytes(SLEN, ok);
    checks++; if (got_q.size() != SLEN) begin failures++; $display("FAIL checker_count got=%0d exp=%0d", got_q.size(), SLEN); end
    for (int i = 0; i < SLEN && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == SLEN - 1)) begin
        failures++;
        $display("FAIL checker_byte %0d got data=%h last=%b exp data=%h last=%b", i, got_q[i], got_last_q[i], exp_q[i], (i == SLEN - 1));
      end
    end
  endtask

  task automatic test_single_one();
    bit ok;
    do_reset();
    bus.out_ready = 1'b1;
    send_range(3, 1'b0, 0, 384);
    push_exp(3);
    wait_bytes(SLEN, ok);
    checks++; if (got_q.size() != SLEN) begin failures++; $display("FAIL single_count got=%0d exp=%0d", got_q.size(), SLEN); end
    for (int i = 0; i < SLEN && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == SLEN - 1)) begin
        failures++;
        $display("FAIL single_byte %0d got data=%h last=%b exp data=%h last=%b", i, got_q[i], got_last_q[i], exp_q[i], (i == SLEN - 1));
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    send_range(1, 1'b0, 0, 384);
    send_range(2, 1'b0, 0, 384);
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", bus.overflow); end
    send_range(3, 1'b0, 0, 1);
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_first_bin got=%b exp=1", bus.overflow); end
    send_range(3, 1'b0, 1, 383);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hFF || bus.out_last !== 1'b0) begin
        failures++;
        $display("FAIL ovf_stall_hold got valid=%b data=%h last=%b exp valid=1 data=ff last=0", bus.out_valid, bus.out_data, bus.out_last);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    push_exp(1);
    push_exp(2);
    wait_bytes(2 * SLEN, ok);
    checks++; if (got_q.size() != 2 * SLEN) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), 2 * SLEN); end
    for (int i = 0; i < 2 * SLEN && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i % SLEN == SLEN - 1)) begin
        failures++;
        $display("FAIL ovf_byte %0d got data=%h last=%b exp data=%h last=%b", i, got_q[i], got_last_q[i], exp_q[i], (i % SLEN == SLEN - 1));
      end
    end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    send_range(1, 1'b0, 0, 384);
    send_range(0, 1'b0, 0, 384);
    bus.out_ready = 1'b1;
    repeat (SLEN - 1) @(posedge clk);
    #1;
    checks++; if (bus.out_last !== 1'b1) begin failures++; $display("FAIL b2b_last_align got=%b exp=1", bus.out_last); end
    send_range(2, 1'b0, 0, 1);
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b exp=0", bus.overflow); end
    send_range(2, 1'b0, 1, 383);
    push_exp(1);
    push_exp(0);
    push_exp(2);
    wait_bytes(3 * SLEN, ok);
    checks++; if (got_q.size() != 3 * SLEN) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), 3 * SLEN); end
    for (int i = 0; i < 3 * SLEN && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i % SLEN == SLEN - 1)) begin
        failures++;
        $display("FAIL b2b_byte %0d got data=%h last=%b exp data=%h last=%b", i, got_q[i], got_last_q[i], exp_q[i], (i % SLEN == SLEN - 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_checkerboard();
    test_single_one();
    test_overflow();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
